// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding-select
// encoding and the iterative-multiplier state encoding.
// The multiplier is present only when EX_MUL_EN is defined.
package ex_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_WB    = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low DATA_W
// bits of the product. start is accepted only in IDLE; busy is high while
// iterating; done is high for the single cycle the product is valid.
// Built only when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    mul_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // FSM state register; reset wins over an iteration in flight
    always_ff @(posedge clk) begin
        if (!rstn) state <= MUL_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_RUN;
            MUL_RUN:  if (cnt == CNT_W'(1)) state_nxt = MUL_DONE;
            MUL_DONE: state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    // shift-add datapath: load operands on start, one partial product per RUN cycle
    always_ff @(posedge clk) begin
        if (state == MUL_IDLE && start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CNT_W'(MUL_CYCLES);
        end else if (state == MUL_RUN) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    assign idle    = (state == MUL_IDLE);
    assign busy    = (state == MUL_RUN);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from EX/MEM and MEM/WB, ALU, destination
// select, branch resolution and the registered EX/MEM bundle.
// Define EX_MUL_EN to build the iterative multiplier for alu_op 111, which
// raises ex_busy to freeze the front end; otherwise alu_op 111 is an add.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  reg_dst,
    input  logic                  alu_src,
    input  logic                  mem_to_reg,
    input  logic                  reg_w,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic                  branch,
    input  logic [2:0]            alu_op,
    input  logic                  bubble,
    input  logic [DATA_W-1:0]     pc_next,
    input  logic [DATA_W-1:0]     ra_data,
    input  logic [DATA_W-1:0]     rb_data,
    input  logic [DATA_W-1:0]     imme_32,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd_for_rtype,
    input  logic                  wb_reg_w,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  ex_busy,
    output logic                  exmem_reg_w,
    output logic                  exmem_mem_to_reg,
    output logic                  exmem_mem_r,
    output logic                  exmem_mem_w,
    output logic [DATA_W-1:0]     exmem_alu_out,
    output logic [DATA_W-1:0]     exmem_store_data,
    output logic [REG_ADDR_W-1:0] exmem_rd,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_target
);

    // The multiplier retires one bit per cycle, so its iteration count is tied to the width.
    if (MUL_CYCLES != DATA_W) begin : g_cfg_check
        $error("ex_stage: MUL_CYCLES must equal DATA_W");
    end

    logic [1:0]               sel_a_p0, sel_b_p0;
    logic signed [DATA_W-1:0] fwd_a_p0, fwd_b_p0, alu_b_p0;
    logic [DATA_W-1:0]        alu_out_p0, target_p0;
    logic [REG_ADDR_W-1:0]    dest_p0;
    logic                     taken_p0;
    logic                     vld_p0;

    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_dst
    );
        if (mem_we && mem_dst != '0 && mem_dst == src) return FWD_EXMEM;
        if (wb_we && wb_dst != '0 && wb_dst == src)    return FWD_WB;
        return FWD_REG;
    endfunction

    // Wrap-around ALU. ALU_MUL falls back to add: without the multiplier that
    // is the defined behaviour, with it the iterative unit supplies the result.
    function automatic logic [DATA_W-1:0] alu_fn(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_NOR: r = ~(a | b);
            ALU_XOR: r = a ^ b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // operand forwarding muxes for A (rs) and B (rt)
    always_comb begin
        sel_a_p0 = fwd_sel(rs, exmem_reg_w, exmem_rd, wb_reg_w, wb_rd);
        sel_b_p0 = fwd_sel(rt, exmem_reg_w, exmem_rd, wb_reg_w, wb_rd);
        case (sel_a_p0)
            FWD_EXMEM: fwd_a_p0 = exmem_alu_out;
            FWD_WB:    fwd_a_p0 = wb_data;
            default:   fwd_a_p0 = ra_data;
        endcase
        case (sel_b_p0)
            FWD_EXMEM: fwd_b_p0 = exmem_alu_out;
            FWD_WB:    fwd_b_p0 = wb_data;
            default:   fwd_b_p0 = rb_data;
        endcase
    end

    assign alu_b_p0   = alu_src ? imme_32 : fwd_b_p0;
    assign alu_out_p0 = alu_fn(alu_op, fwd_a_p0, alu_b_p0);
    assign dest_p0    = reg_dst ? rd_for_rtype : rt;
    // A - B == 0 under wrap-around is plain equality
    assign taken_p0   = branch & (fwd_a_p0 == alu_b_p0);
    assign target_p0  = pc_next + (imme_32 << 2);
    assign vld_p0     = !bubble && !ex_busy;

`ifdef EX_MUL_EN
    logic                  mul_start, mul_idle, mul_busy, mul_done;
    logic [DATA_W-1:0]     mul_product;
    logic                  mul_reg_w, mul_mem_to_reg, mul_mem_r, mul_mem_w;
    logic [REG_ADDR_W-1:0] mul_rd;

    assign mul_start = (alu_op == ALU_MUL) && !bubble;
    // busy from the cycle the op is presented until the last iteration
    assign ex_busy   = mul_busy | (mul_idle & mul_start);

    ex_iter_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rstn    (rstn),
        .start   (mul_start),
        .a       (fwd_a_p0),
        .b       (alu_b_p0),
        .idle    (mul_idle),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // capture the multiply's destination and control for retirement in DONE
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mul_reg_w      <= 1'b0;
            mul_mem_to_reg <= 1'b0;
            mul_mem_r      <= 1'b0;
            mul_mem_w      <= 1'b0;
            mul_rd         <= '0;
        end else if (mul_idle && mul_start) begin
            mul_reg_w      <= reg_w;
            mul_mem_to_reg <= mem_to_reg;
            mul_mem_r      <= mem_r;
            mul_mem_w      <= mem_w;
            mul_rd         <= dest_p0;
        end
    end
`else
    assign ex_busy = 1'b0;
`endif

    // ---- EX -> MEM stage boundary ----
    // EX/MEM register: reset, multiply retirement, NOP on bubble/busy, or the EX result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            exmem_reg_w      <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_mem_r      <= 1'b0;
            exmem_mem_w      <= 1'b0;
            exmem_alu_out    <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            branch_taken     <= 1'b0;
            branch_target    <= '0;
        end
`ifdef EX_MUL_EN
        else if (mul_done) begin
            exmem_reg_w      <= mul_reg_w;
            exmem_mem_to_reg <= mul_mem_to_reg;
            exmem_mem_r      <= mul_mem_r;
            exmem_mem_w      <= mul_mem_w;
            exmem_alu_out    <= mul_product;
            exmem_store_data <= '0;
            exmem_rd         <= mul_rd;
            branch_taken     <= 1'b0;
            branch_target    <= '0;
        end
`endif
        else if (!vld_p0) begin
            exmem_reg_w      <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_mem_r      <= 1'b0;
            exmem_mem_w      <= 1'b0;
            exmem_alu_out    <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            branch_taken     <= 1'b0;
            branch_target    <= '0;
        end else begin
            exmem_reg_w      <= reg_w;
            exmem_mem_to_reg <= mem_to_reg;
            exmem_mem_r      <= mem_r;
            exmem_mem_w      <= mem_w;
            exmem_alu_out    <= alu_out_p0;
            exmem_store_data <= fwd_b_p0;
            exmem_rd         <= dest_p0;
            branch_taken     <= taken_p0;
            branch_target    <= target_p0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a behavioural model predicts the EX/MEM
// bundle after every edge and ex_busy within every cycle; a monitor compares
// the registered outputs. Multiply expectations follow EX_MUL_EN.
module tb_ex_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_dst = 1'b0, alu_src = 1'b0, mem_to_reg = 1'b0, reg_w = 1'b0;
    logic        mem_r = 1'b0, mem_w = 1'b0, branch = 1'b0, bubble = 1'b1;
    logic [2:0]  alu_op = 3'd0;
    logic [31:0] pc_next = '0, ra_data = '0, rb_data = '0, imme_32 = '0, wb_data = '0;
    logic [4:0]  rs = '0, rt = '0, rd_for_rtype = '0, wb_rd = '0;
    logic        wb_reg_w = 1'b0;
    logic        ex_busy;
    logic        exmem_reg_w, exmem_mem_to_reg, exmem_mem_r, exmem_mem_w;
    logic [31:0] exmem_alu_out, exmem_store_data, branch_target;
    logic [4:0]  exmem_rd;
    logic        branch_taken;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rstn(rstn), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_w(reg_w), .mem_r(mem_r), .mem_w(mem_w),
        .branch(branch), .alu_op(alu_op), .bubble(bubble), .pc_next(pc_next),
        .ra_data(ra_data), .rb_data(rb_data), .imme_32(imme_32), .rs(rs), .rt(rt),
        .rd_for_rtype(rd_for_rtype), .wb_reg_w(wb_reg_w), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_busy(ex_busy), .exmem_reg_w(exmem_reg_w),
        .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_mem_r(exmem_mem_r),
        .exmem_mem_w(exmem_mem_w), .exmem_alu_out(exmem_alu_out),
        .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    typedef struct packed {
        logic        rstn;
        logic        reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w, branch;
        logic [2:0]  alu_op;
        logic        bubble;
        logic [31:0] pc_next, ra, rb, imm;
        logic [4:0]  rs, rt, rd;
        logic        wb_reg_w;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } in_t;

    typedef struct packed {
        logic        reg_w, mem_to_reg, mem_r, mem_w;
        logic [31:0] alu_out, store_data;
        logic [4:0]  rd;
        logic        taken;
        logic [31:0] target;
    } exmem_t;

    exmem_t exp_q[$];
    exmem_t m_q = '0;      // model's EX/MEM contents after the most recent edge
    exmem_t m_res = '0;    // pending multiply result
    bit     m_pend = 0;    // a multiply has been accepted and not yet retired
    int     m_left = 0;    // iteration cycles still to run before retirement
    bit     busy_known = 0;
    logic   last_busy = 1'b0;
    int     n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regv, input in_t x);
        if (m_q.reg_w && m_q.rd != 5'd0 && m_q.rd == src) return m_q.alu_out;
        if (x.wb_reg_w && x.wb_rd != 5'd0 && x.wb_rd == src) return x.wb_data;
        return regv;
    endfunction

    function automatic in_t base();
        in_t x = '0;
        x.rstn = 1'b1;
        return x;
    endfunction

    // Drive one cycle of ID/EX inputs, predict the result of the coming edge.
    task automatic do_cycle(input in_t x);
        exmem_t      nxt;
        logic [31:0] a, b, bsel;
        logic        start, busy_exp, idle, running, done_st;
        @(negedge clk);
        rstn = x.rstn; reg_dst = x.reg_dst; alu_src = x.alu_src; mem_to_reg = x.mem_to_reg;
        reg_w = x.reg_w; mem_r = x.mem_r; mem_w = x.mem_w; branch = x.branch;
        alu_op = x.alu_op; bubble = x.bubble; pc_next = x.pc_next; ra_data = x.ra;
        rb_data = x.rb; imme_32 = x.imm; rs = x.rs; rt = x.rt; rd_for_rtype = x.rd;
        wb_reg_w = x.wb_reg_w; wb_rd = x.wb_rd; wb_data = x.wb_data;
        idle    = !m_pend;
        running = m_pend && (m_left > 0);
        done_st = m_pend && (m_left == 0);
`ifdef EX_MUL_EN
        start = (x.alu_op == 3'd7) && !x.bubble;
`else
        start = 1'b0;
`endif
        busy_exp = (idle && start) || running;
        a    = ref_fwd(x.rs, x.ra, x);
        b    = ref_fwd(x.rt, x.rb, x);
        bsel = x.alu_src ? x.imm : b;
        nxt  = '0;
        if (!x.rstn) begin
            m_pend = 0;
        end else if (done_st) begin
            nxt    = m_res;
            m_pend = 0;
        end else if (running) begin
            m_left--;
        end else if (idle && start) begin
            m_pend           = 1;
            m_left           = MUL_CYCLES;
            m_res            = '0;
            m_res.reg_w      = x.reg_w;
            m_res.mem_to_reg = x.mem_to_reg;
            m_res.mem_r      = x.mem_r;
            m_res.mem_w      = x.mem_w;
            m_res.alu_out    = a * bsel;
            m_res.rd         = x.reg_dst ? x.rd : x.rt;
        end else if (!x.bubble) begin
            nxt.reg_w      = x.reg_w;
            nxt.mem_to_reg = x.mem_to_reg;
            nxt.mem_r      = x.mem_r;
            nxt.mem_w      = x.mem_w;
            nxt.alu_out    = ref_alu(x.alu_op, a, bsel);
            nxt.store_data = b;
            nxt.rd         = x.reg_dst ? x.rd : x.rt;
            nxt.taken      = x.branch && ((a - bsel) == 32'd0);
            nxt.target     = x.pc_next + (x.imm << 2);
        end
        exp_q.push_back(nxt);
        #1;
        last_busy = ex_busy;
        if (busy_known) chk("ex_busy", 128'(ex_busy), 128'(busy_exp));
        m_q = nxt;
        if (!x.rstn) busy_known = 1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // monitor: compare the registered bundle against the scoreboard after each edge
    initial begin
        exmem_t e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {exmem_reg_w, exmem_mem_to_reg, exmem_mem_r, exmem_mem_w, exmem_alu_out,
                       exmem_store_data, exmem_rd, branch_taken, branch_target};
                chk("exmem_bundle", 128'(act), 128'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected to finish earlier");
        $fatal(1);
    end

    initial begin
        in_t x;
        int  busy_cnt;

        // reset with every input driven high
        x = '1;
        x.rstn = 1'b0;
        do_cycle(x);
        after_edge();
        chk("rst_ctrl", 128'({exmem_reg_w, exmem_mem_to_reg, exmem_mem_r, exmem_mem_w, branch_taken}), 128'(0));
        chk("rst_data", 128'({exmem_alu_out, exmem_store_data, exmem_rd, branch_target}), 128'(0));
        do_cycle(x);
        chk("rst_busy", 128'(last_busy), 128'(0));

        // add 5 + 7 into r9
        x = base(); x.rs = 5'd3; x.rt = 5'd4; x.ra = 32'd5; x.rb = 32'd7;
        x.reg_dst = 1'b1; x.rd = 5'd9; x.reg_w = 1'b1;
        do_cycle(x);
        after_edge();
        chk("add_alu_out", 128'(exmem_alu_out), 128'(32'd12));
        chk("add_rd", 128'(exmem_rd), 128'(5'd9));
        chk("add_reg_w", 128'(exmem_reg_w), 128'(1'b1));

        // EX/MEM r3 = 0x10 while MEM/WB r3 = 0x20: EX/MEM wins
        x = base(); x.ra = 32'h10; x.reg_dst = 1'b1; x.rd = 5'd3; x.reg_w = 1'b1;
        do_cycle(x);
        x = base(); x.alu_op = 3'd1; x.rs = 5'd3; x.rt = 5'd5; x.ra = 32'h99; x.rb = 32'd4;
        x.reg_dst = 1'b1; x.rd = 5'd6; x.reg_w = 1'b1;
        x.wb_reg_w = 1'b1; x.wb_rd = 5'd3; x.wb_data = 32'h20;
        do_cycle(x);
        after_edge();
        chk("fwd_exmem", 128'(exmem_alu_out), 128'(32'h0C));

        // same pattern with destination r0: nothing forwards
        x = base(); x.ra = 32'h10; x.reg_dst = 1'b1; x.rd = 5'd0; x.reg_w = 1'b1;
        do_cycle(x);
        x = base(); x.alu_op = 3'd1; x.rs = 5'd0; x.rt = 5'd5; x.ra = 32'h99; x.rb = 32'd4;
        x.reg_dst = 1'b1; x.rd = 5'd6; x.reg_w = 1'b1;
        x.wb_reg_w = 1'b1; x.wb_rd = 5'd0; x.wb_data = 32'h20;
        do_cycle(x);
        after_edge();
        chk("fwd_r0", 128'(exmem_alu_out), 128'(32'h95));

        // only MEM/WB matches
        x = base(); x.alu_op = 3'd1; x.rs = 5'd3; x.rt = 5'd5; x.ra = 32'h99; x.rb = 32'd4;
        x.reg_dst = 1'b1; x.rd = 5'd6; x.reg_w = 1'b1;
        x.wb_reg_w = 1'b1; x.wb_rd = 5'd3; x.wb_data = 32'h20;
        do_cycle(x);
        after_edge();
        chk("fwd_wb", 128'(exmem_alu_out), 128'(32'h1C));

        // beq with equal operands
        x = base(); x.alu_op = 3'd1; x.branch = 1'b1; x.rs = 5'd1; x.rt = 5'd2;
        x.ra = 32'h55; x.rb = 32'h55; x.pc_next = 32'h40; x.imm = 32'd3;
        do_cycle(x);
        after_edge();
        chk("beq_taken", 128'(branch_taken), 128'(1'b1));
        chk("beq_target", 128'(branch_target), 128'(32'h4C));
        x.bubble = 1'b1;
        do_cycle(x);
        after_edge();
        chk("beq_bubble_taken", 128'(branch_taken), 128'(1'b0));
        chk("beq_bubble_ctrl", 128'({exmem_reg_w, exmem_mem_to_reg, exmem_mem_r, exmem_mem_w}), 128'(0));

        // 0xFFFFFFFF * 3 into r7, then a dependent add
        x = base(); x.alu_op = 3'd7; x.rs = 5'd1; x.rt = 5'd2; x.ra = 32'hFFFF_FFFF;
        x.rb = 32'd3; x.reg_dst = 1'b1; x.rd = 5'd7; x.reg_w = 1'b1;
`ifdef EX_MUL_EN
        busy_cnt = 0;
        for (int i = 0; i < MUL_CYCLES + 2; i++) begin
            do_cycle(x);
            if (last_busy) busy_cnt++;
        end
        chk("mul_busy_cycles", 128'(busy_cnt), 128'(MUL_CYCLES + 1));
        after_edge();
        chk("mul_product", 128'(exmem_alu_out), 128'(32'hFFFF_FFFD));
        chk("mul_rd", 128'(exmem_rd), 128'(5'd7));
`else
        busy_cnt = 0;
        do_cycle(x);
        after_edge();
        chk("op7_as_add", 128'(exmem_alu_out), 128'(32'd2));
`endif
        x = base(); x.rs = 5'd7; x.rt = 5'd0; x.rb = 32'd5; x.reg_dst = 1'b1; x.rd = 5'd8; x.reg_w = 1'b1;
        do_cycle(x);
        after_edge();
`ifdef EX_MUL_EN
        chk("mul_followon_add", 128'(exmem_alu_out), 128'(32'd2));
`else
        chk("followon_add", 128'(exmem_alu_out), 128'(32'd7));
`endif

`ifdef EX_MUL_EN
        // reset during a multiply, then a fresh one
        x = base(); x.alu_op = 3'd7; x.rs = 5'd1; x.rt = 5'd2; x.ra = 32'd6; x.rb = 32'd7;
        x.reg_dst = 1'b1; x.rd = 5'd10; x.reg_w = 1'b1;
        for (int i = 0; i < 10; i++) do_cycle(x);
        x.rstn = 1'b0;
        do_cycle(x);
        x.rstn = 1'b1;
        x.bubble = 1'b1;
        do_cycle(x);
        chk("rst_mid_busy", 128'(last_busy), 128'(0));
        chk("rst_mid_out", 128'({exmem_reg_w, exmem_alu_out, exmem_rd}), 128'(0));
        x.bubble = 1'b0;
        for (int i = 0; i < MUL_CYCLES + 2; i++) do_cycle(x);
        after_edge();
        chk("mul_after_rst", 128'(exmem_alu_out), 128'(32'd42));
`endif

        // randomized traffic on a small register set so forwarding hits often
        for (int n = 0; n < 1500; n++) begin
            x = base();
            x.rstn       = ($urandom_range(0, 99) != 0);
            x.bubble     = ($urandom_range(0, 4) == 0);
            x.alu_op     = 3'($urandom_range(0, 7));
            if (x.alu_op == 3'd7 && $urandom_range(0, 3) != 0) x.alu_op = 3'($urandom_range(0, 6));
            x.reg_dst    = 1'($urandom);
            x.mem_to_reg = 1'($urandom);
            x.reg_w      = 1'($urandom);
            x.mem_r      = 1'($urandom);
            x.mem_w      = 1'($urandom);
            x.branch     = 1'($urandom);
            x.alu_src    = x.branch ? 1'b0 : 1'($urandom);
            x.pc_next    = $urandom;
            x.ra         = ($urandom_range(0, 2) == 0) ? 32'h55 : $urandom;
            x.rb         = ($urandom_range(0, 2) == 0) ? 32'h55 : $urandom;
            x.imm        = $urandom;
            x.rs         = 5'($urandom_range(0, 3));
            x.rt         = 5'($urandom_range(0, 3));
            x.rd         = 5'($urandom_range(0, 3));
            x.wb_reg_w   = 1'($urandom);
            x.wb_rd      = 5'($urandom_range(0, 3));
            x.wb_data    = ($urandom_range(0, 2) == 0) ? 32'h55 : $urandom;
            do_cycle(x);
        end

        x = base();
        x.bubble = 1'b1;
        do_cycle(x);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
